tmds_serial_sequencer: RTL
==========================

TMDS_SERIAL_SEQUENCER -- requirements
Module: tmds_serial_sequencer

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning active pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, meaning horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, meaning vertical timing in lines.
REQ-004 SHALL have parameter SYNC_NEG, default 1, meaning the sync level sent in control symbols is inverted (negative polarity).
REQ-005 SHALL have port clk, input, 1, bit clock (one TMDS bit per cycle); this is the single clock.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports sym_d0/sym_d1/sym_d2, input, 10 each, pre-encoded TMDS symbols for lanes 0..2.
REQ-008 SHALL have port sym_valid, input, 1, and port sym_ready, output, 1, forming the symbol handshake.
REQ-009 SHALL have port px_x, output, 11, and port px_y, output, 10, giving the position of the pixel being requested.
REQ-010 SHALL have ports de/hsync/vsync, output, 1 each, giving the timing of the requested pixel (logical active-high sync).
REQ-011 SHALL have port frame_start, output, 1, a one-cycle pulse on the request of pixel (0,0).
REQ-012 SHALL have port tmds_d, output, 3, and port tmds_clk, output, 1, the serial lane bits driving the LVDS buffers.
REQ-013 SHALL have port underflow, output, 1, a one-cycle pulse when an active symbol is missing.

Function
REQ-014 SHALL run bit counter bit_cnt 0..9, incrementing every cycle and wrapping 9->0.
REQ-015 SHALL load the three lane shift registers when bit_cnt==9, so that the new symbol's bit 0 appears on tmds_d in the following cycle.
REQ-016 SHALL shift LSB first, one bit per cycle, with tmds_d[n] registered directly from shift register bit 0.
REQ-017 SHALL drive tmds_clk=1 for bit_cnt 0..4 and 0 for bit_cnt 5..9, aligned to the data lanes.
REQ-018 SHALL keep h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1 (totals are the sums of their four parameters), advancing h_cnt at each load, and advancing v_cnt when h_cnt wraps.
REQ-019 SHALL compute de as (h_cnt<H_ACTIVE && v_cnt<V_ACTIVE).
REQ-020 SHALL assert hsync for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
REQ-021 SHALL assert vsync for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
REQ-022 SHALL present px_x/px_y/de/hsync/vsync for the next symbol during bit_cnt 0..9, so they are stable before the load.
REQ-023 SHALL assert sym_ready only in the cycle bit_cnt==9 and only when de is 1; a symbol transfers when sym_valid && sym_ready.
REQ-024 SHALL load CTRL symbols during blanking: lane0 = CTRL[{vsync^SYNC_NEG, hsync^SYNC_NEG}], and lanes 1 and 2 = CTRL[00].
REQ-025 SHALL, when an active load finds sym_valid=0, load CTRL[00] on all lanes, pulse underflow, and advance timing normally without stalling.
REQ-026 SHALL ignore sym_valid outside sym_ready cycles, and SHALL NOT hold any symbol across load slots.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously clear bit_cnt, h_cnt, v_cnt, all shift registers, tmds_d, tmds_clk, sym_ready, underflow, and frame_start.
REQ-028 SHALL, on reset release, take the first load at the 10th cycle (bit_cnt==9) for pixel (0,0), with frame_start and sym_ready pulsing in that cycle.
REQ-029 SHALL, on reset asserted mid-symbol or mid-frame, abandon the partial symbol, and SHALL restart at pixel (0,0) after release.

Configuration
REQ-030 SHALL, with TMDS_UNDERFLOW_CNT_EN defined, add output underflow_cnt, 16 bits, which counts underflow pulses, saturates at 0xFFFF, and clears on reset.
REQ-031 SHALL, without TMDS_UNDERFLOW_CNT_EN, omit underflow_cnt entirely, and SHALL still provide the underflow pulse.

Structure
REQ-032 SHALL take the four CTRL symbol constants (0x354, 0x0AB, 0x154, 0x2AB for 00/01/10/11) and a timing-parameter struct typedef from shared package tmds_pkg.
REQ-033 SHALL instantiate sub-module tmds_shift10 (10-bit parallel-load shift register with load/shift), three times, once per data lane.

Verification
REQ-034 SHALL verify reset release: tmds_clk shows 1111100000 from cycle 1, and sym_ready plus frame_start pulse at cycle 10 with px_x=0, px_y=0.
REQ-035 SHALL verify the data path: sym_d0=0x2AA held valid -> tmds_d[0] serial stream 0,1,0,1,0,1,0,1,0,1 (LSB first) during the next 10 cycles.
REQ-036 SHALL verify blanking: at h_cnt=656 with SYNC_NEG=1 -> lane0 carries 0x154 (vsync inactive, hsync active); at h_cnt=640 -> 0x2AB.
REQ-037 SHALL verify underflow: sym_valid=0 at active pixel (5,0) -> all lanes load 0x354, underflow pulses once, and pixel (6,0) is requested next.
REQ-038 SHALL verify line and frame wrap: after 800 loads px_y increments; after 800*525 loads frame_start pulses again with px_x=0, px_y=0.
REQ-039 SHALL verify the counter: with TMDS_UNDERFLOW_CNT_EN, 3 forced underflows -> underflow_cnt=3, and underflow_cnt returns to 0 after a reset pulse mid-frame.

Source files
------------

// File: rtl/tmds_pkg.sv
// tmds_pkg -- shared definitions for the TMDS serial sequencer.
//   CTRL_00..CTRL_11 : TMDS control-period symbols, indexed by {c1, c0}
//   tmds_timing_t    : horizontal/vertical video timing bundle
//   ctrl_sym()       : selects the control symbol for a 2-bit control code
package tmds_pkg;

    localparam logic [9:0] CTRL_00 = 10'h354;
    localparam logic [9:0] CTRL_01 = 10'h0AB;
    localparam logic [9:0] CTRL_10 = 10'h154;
    localparam logic [9:0] CTRL_11 = 10'h2AB;

    typedef struct packed {
        logic [10:0] h_active;
        logic [10:0] h_fp;
        logic [10:0] h_sync;
        logic [10:0] h_bp;
        logic [9:0]  v_active;
        logic [9:0]  v_fp;
        logic [9:0]  v_sync;
        logic [9:0]  v_bp;
    } tmds_timing_t;

    function automatic logic [9:0] ctrl_sym(input logic [1:0] code);
        logic [9:0] sym;
        case (code)
            2'b00:   sym = CTRL_00;
            2'b01:   sym = CTRL_01;
            2'b10:   sym = CTRL_10;
            default: sym = CTRL_11;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/tmds_shift10.sv
// tmds_shift10 -- 10-bit parallel-load, LSB-first shift register for one lane.
//   clk, rst_n : bit clock, asynchronous active-low reset
//   load       : capture d (takes priority over shift)
//   shift      : move one bit toward bit 0, zero-filling from the top
//   d          : parallel symbol
//   sout       : register bit 0, the serial lane bit
module tmds_shift10 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       shift,
    input  logic [9:0] d,
    output logic       sout
);

    logic [9:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= d;
        end else if (shift) begin
            sr <= {1'b0, sr[9:1]};
        end
    end

    assign sout = sr[0];

endmodule

// File: rtl/tmds_serial_sequencer.sv
// tmds_serial_sequencer -- serialises three pre-encoded TMDS lanes at one bit
// per clock and generates the video timing that paces symbol requests.
//   clk, rst_n            : bit clock, asynchronous active-low reset
//   sym_d0/1/2            : encoded symbols for lanes 0..2
//   sym_valid / sym_ready : symbol handshake, ready only at active load slots
//   px_x, px_y            : position of the pixel being requested
//   de, hsync, vsync      : timing of that pixel (active-high)
//   frame_start           : pulse on the request of pixel (0,0)
//   tmds_d, tmds_clk      : serial lane bits and the 5-high/5-low TMDS clock
//   underflow             : pulse when an active slot finds no symbol
//   underflow_cnt         : saturating underflow count, present only when
//                           TMDS_UNDERFLOW_CNT_EN is defined
module tmds_serial_sequencer
    import tmds_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_NEG = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  sym_d0,
    input  logic [9:0]  sym_d1,
    input  logic [9:0]  sym_d2,
    input  logic        sym_valid,
    output logic        sym_ready,
    output logic [10:0] px_x,
    output logic [9:0]  px_y,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic [2:0]  tmds_d,
    output logic        tmds_clk,
    output logic        underflow
`ifdef TMDS_UNDERFLOW_CNT_EN
    ,
    output logic [15:0] underflow_cnt
`endif
);

    localparam tmds_timing_t TIMING = '{
        h_active: H_ACTIVE[10:0], h_fp: H_FP[10:0],
        h_sync:   H_SYNC[10:0],   h_bp: H_BP[10:0],
        v_active: V_ACTIVE[9:0],  v_fp: V_FP[9:0],
        v_sync:   V_SYNC[9:0],    v_bp: V_BP[9:0]
    };

    localparam logic [10:0] H_LAST   = TIMING.h_active + TIMING.h_fp + TIMING.h_sync + TIMING.h_bp - 11'd1;
    localparam logic [9:0]  V_LAST   = TIMING.v_active + TIMING.v_fp + TIMING.v_sync + TIMING.v_bp - 10'd1;
    localparam logic [10:0] HS_START = TIMING.h_active + TIMING.h_fp;
    localparam logic [10:0] HS_END   = HS_START + TIMING.h_sync;
    localparam logic [9:0]  VS_START = TIMING.v_active + TIMING.v_fp;
    localparam logic [9:0]  VS_END   = VS_START + TIMING.v_sync;

    // active is low for the first cycle after reset so that the cycle with
    // bit_cnt==0 is the first one to show tmds_clk high.
    logic        active;
    logic [3:0]  bit_cnt;
    logic [3:0]  bit_cnt_nxt;
    logic        load;
    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic [9:0]  lane0_sym;
    logic [9:0]  lane1_sym;
    logic [9:0]  lane2_sym;

    always_comb begin
        load        = active && (bit_cnt == 4'd9);
        bit_cnt_nxt = (!active || bit_cnt == 4'd9) ? 4'd0 : bit_cnt + 4'd1;
        de          = (h_cnt < TIMING.h_active) && (v_cnt < TIMING.v_active);
        hsync       = (h_cnt >= HS_START) && (h_cnt < HS_END);
        vsync       = (v_cnt >= VS_START) && (v_cnt < VS_END);
        sym_ready   = load && de;
        underflow   = sym_ready && !sym_valid;
        frame_start = load && (h_cnt == 11'd0) && (v_cnt == 10'd0);

        lane0_sym = CTRL_00;
        lane1_sym = CTRL_00;
        lane2_sym = CTRL_00;
        if (de) begin
            // A missing active symbol falls back to CTRL_00 on every lane.
            if (sym_valid) begin
                lane0_sym = sym_d0;
                lane1_sym = sym_d1;
                lane2_sym = sym_d2;
            end
        end else begin
            lane0_sym = ctrl_sym({vsync ^ SYNC_NEG, hsync ^ SYNC_NEG});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            bit_cnt  <= 4'd0;
            tmds_clk <= 1'b0;
            h_cnt    <= 11'd0;
            v_cnt    <= 10'd0;
        end else begin
            active   <= 1'b1;
            bit_cnt  <= bit_cnt_nxt;
            // Registered from the next bit index so it lines up with the
            // shift-register outputs.
            tmds_clk <= (bit_cnt_nxt < 4'd5);
            if (load) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= 11'd0;
                    v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
                end else begin
                    h_cnt <= h_cnt + 11'd1;
                end
            end
        end
    end

    assign px_x = h_cnt;
    assign px_y = v_cnt;

    tmds_shift10 u_lane0 (.clk(clk), .rst_n(rst_n), .load(load), .shift(active),
                          .d(lane0_sym), .sout(tmds_d[0]));
    tmds_shift10 u_lane1 (.clk(clk), .rst_n(rst_n), .load(load), .shift(active),
                          .d(lane1_sym), .sout(tmds_d[1]));
    tmds_shift10 u_lane2 (.clk(clk), .rst_n(rst_n), .load(load), .shift(active),
                          .d(lane2_sym), .sout(tmds_d[2]));

`ifdef TMDS_UNDERFLOW_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow_cnt <= 16'd0;
        end else if (underflow && underflow_cnt != 16'hFFFF) begin
            underflow_cnt <= underflow_cnt + 16'd1;
        end
    end
`endif

endmodule
